// File: rtl/ioctrl_mc.sv
// Registered CPU-to-peripheral IO controller: slot decode, wait-state access with timeout, four-phase ready.
// Latency 2+ cycles (error 1); backpressure: ready/error held until the CPU drops read and write.
`ifndef IO_ADDR_WIDTH
`define IO_ADDR_WIDTH 32
`endif
`ifndef IO_DATA_WIDTH
`define IO_DATA_WIDTH 32
`endif

module ioctrl_mc #(
  parameter int ADDR_WIDTH = `IO_ADDR_WIDTH,
  parameter int DATA_WIDTH = `IO_DATA_WIDTH,
  parameter int SLOTS      = 4,
  parameter int SLOT_BITS  = 2,
  parameter int TIMEOUT    = 15,
  parameter int TO_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  read,
  input  logic                  write,
  output logic                  ready,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] io_addr,
  inout  wire  [DATA_WIDTH-1:0] io_data,
  output logic                  io_read,
  output logic                  io_write,
  output logic [SLOTS-1:0]      io_sel,
  input  logic [SLOTS-1:0]      io_ready
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdat;
    logic [SLOT_BITS-1:0]  slot;
    logic                  is_rd;
  } req_t;

  state_t                state_q, state_d;
  req_t                  req_q;
  logic [TO_WIDTH-1:0]   cnt_q;
  logic [DATA_WIDTH-1:0] rdat_q;
  logic                  error_q;

  logic [SLOT_BITS-1:0]  slot_in;
  logic                  req_any, req_one, mapped, slot_rdy, timed_out;
  logic [SLOTS-1:0]      sel_oh;

  assign slot_in   = addr[ADDR_WIDTH-1 -: SLOT_BITS];
  assign req_any   = read | write;
  assign req_one   = read ^ write;
  assign mapped    = 32'(slot_in) < SLOTS;
  assign timed_out = (cnt_q == TO_WIDTH'(TIMEOUT - 1));
  assign slot_rdy  = |(io_ready & sel_oh);

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < SLOTS; i++) begin
      sel_oh[i] = (req_q.slot == SLOT_BITS'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_any) state_d = (req_one && mapped) ? ACCESS : DONE;
      ACCESS:  if (slot_rdy || timed_out) state_d = DONE;
      DONE:    if (!req_any) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      rdat_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_any) begin
            req_q.addr  <= addr;
            req_q.wdat  <= write ? data : '0;
            req_q.slot  <= slot_in;
            req_q.is_rd <= read & ~write;
            cnt_q       <= '0;
            rdat_q      <= '0;
            error_q     <= !(req_one && mapped);
          end
        end
        ACCESS: begin
          if (slot_rdy) begin
            if (req_q.is_rd) rdat_q <= io_data;
            error_q <= 1'b0;
          end else if (timed_out) begin
            rdat_q  <= '0;
            error_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: if (!req_any) error_q <= 1'b0;
        default: error_q <= 1'b0;
      endcase
    end
  end

  // Every output is decoded from registered state, so io_ready never reaches ready combinationally.
  assign ready    = (state_q == DONE);
  assign error    = error_q;
  assign io_sel   = (state_q == ACCESS) ? sel_oh : '0;
  assign io_read  = (state_q == ACCESS) &&  req_q.is_rd;
  assign io_write = (state_q == ACCESS) && !req_q.is_rd;
  assign io_addr  = (state_q == ACCESS) ? req_q.addr : '0;

  assign io_data = ((state_q == ACCESS) && !req_q.is_rd) ? req_q.wdat : 'z;
  assign data    = ((state_q == DONE)   &&  req_q.is_rd) ? rdat_q     : 'z;

endmodule

// File: doc/ioctrl_mc.md
# ioctrl_mc

Multi-slot, registered IO controller between the CPU memory-stage IO port and up to SLOTS peripheral slots on a shared tri-state bus. It decodes the slot from the upper address bits and latches the request. It then runs a wait-state handshake against the selected slot's ready line with a bounded timeout, and completes a four-phase ready/request handshake back to the CPU. Unmapped slots, conflicting strobes and timeouts are reported through an error flag.

## Interface
Parameters:
- ADDR_WIDTH, `IO_ADDR_WIDTH`, CPU/peripheral address width
- DATA_WIDTH, `IO_DATA_WIDTH`, data bus width
- SLOTS, 4, number of peripheral slots (1..2^SLOT_BITS)
- SLOT_BITS, 2, address MSBs used for slot decode
- TIMEOUT, 15, maximum ACCESS cycles waiting for io_ready (1..2^TO_WIDTH-1)
- TO_WIDTH, 4, timeout counter width

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- addr  input  ADDR_WIDTH  CPU IO address
- data  inout  DATA_WIDTH  CPU data; driven by this block only in DONE for reads
- read  input  1  CPU read request, level, held until ready
- write  input  1  CPU write request, level, held until ready
- ready  output  1  transfer complete, held until read and write both low
- error  output  1  qualifies ready: transfer failed (decode/conflict/timeout)
- io_addr  output  ADDR_WIDTH  latched address, zero when idle
- io_data  inout  DATA_WIDTH  peripheral data; driven by this block only in ACCESS for writes
- io_read  output  1  peripheral read strobe
- io_write  output  1  peripheral write strobe
- io_sel  output  SLOTS  one-hot slot select
- io_ready  input  SLOTS  per-slot completion

## Operation
- slot index = addr[ADDR_WIDTH-1 -: SLOT_BITS].
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - read and write both low: stay.
  - Exactly one high and slot < SLOTS: latch addr, direction, data (if write) and slot; clear counter; go ACCESS.
  - Both high, or slot >= SLOTS: set error; go DONE with no peripheral strobe.
- ACCESS:
  - Drive io_sel[slot]=1, io_addr=latched addr, io_read/io_write per direction.
  - Write: io_data = latched write data.
  - io_ready[slot] sampled high: capture io_data on reads; error=0; go DONE.
  - Else, counter == TIMEOUT-1: error=1; go DONE; read data captured as 0.
  - Else: counter+1.
  - io_ready of non-selected slots is ignored.
- DONE:
  - ready=1; strobes and io_sel low; io_data released to z.
  - data driven with captured read data when the latched direction is read; z otherwise.
  - Stay until read and write are both low, then go IDLE. ready and error clear on that transition.
- addr/data/read/write changes during ACCESS are ignored; only the IDLE-sampled values are used.
- Reset (any state, asynchronous): state=IDLE, counter=0, ready=0, error=0, io_sel=0, io_read=0, io_write=0, io_addr=0, io_data=z, data=z, captured data=0. An in-flight access is abandoned with no completion.

## Timing
- All outputs are registered/state-decoded; no combinational path from io_ready to ready.
- Request sampled at edge E0. Strobes are visible from E0 to E1 (first ACCESS cycle).
- io_ready high in the first ACCESS cycle: ready=1 after E1, so minimum latency is 2 cycles from request assertion.
- Each additional io_ready-low cycle adds 1 cycle. Timeout gives error+ready after exactly TIMEOUT ACCESS cycles, i.e. TIMEOUT+1 cycles after E0.
- Decode or conflict error: ready=1,error=1 one cycle after E0.
- Request dropped in the cycle after ready rises: IDLE is reached at the next edge. A new request may be sampled in the following cycle, so back-to-back throughput is ≥ 4 cycles per transfer.
- io_data and data are never driven by this block in the same cycle as the peripheral/CPU under the protocol above.

## Test plan
- Reset mid-ACCESS (assert rst_n=0 while io_sel=4'b0010) -> all outputs return to reset values immediately; next request starts cleanly from IDLE.
- Read, slot 2, addr MSBs=2'b10, io_ready[2] high on the 3rd ACCESS cycle with io_data=32'hDEADBEEF -> io_sel=4'b0100 and io_read=1 for 3 cycles; ready=1, error=0, data=32'hDEADBEEF until read drops.
- Write, slot 0, data=32'h12345678, io_ready[0] high immediately -> io_write=1 and io_data=32'h12345678 for 1 cycle; ready rises 2 cycles after request; error=0.
- Read to slot 1 with io_ready held low (TIMEOUT=15) -> ready=1, error=1 exactly 16 cycles after request; data=0; io_ready[3] pulses during the wait have no effect.
- SLOTS=3 with addr MSBs=2'b11, and separately read=write=1 -> no io strobes; ready=1, error=1 one cycle after request.
- Hold read high after ready -> ready stays 1 and no second access starts; drop read -> ready=0 next cycle, and a new write is accepted the following cycle.
